// File: rtl/scan_mux_pkg.sv
// ============================================================================
// Module  : scan_mux_pkg
// Brief   : Shared mode/state encodings and constant helpers for scan_mux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package scan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res++;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_mux_if.sv
// ============================================================================
// Module  : scan_mux_if
// Brief   : Input bank / control and handshaked output bundle for scan_mux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface scan_mux_if #(
  parameter int N_CH  = 16,
  parameter int WIDTH = 1,
  parameter int SEL_W = 4
) ();

  logic [N_CH*WIDTH-1:0] in;
  logic [SEL_W-1:0]      sel;
  logic                  mode;
  logic                  en;
  logic [WIDTH-1:0]      out;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_err;

  modport master (
    output in, sel, mode, en, out_ready,
    input  out, out_ch, out_valid, out_err
  );

  modport slave (
    input  in, sel, mode, en, out_ready,
    output out, out_ch, out_valid, out_err
  );

endinterface

`default_nettype wire

// File: rtl/scan_mux_counter.sv
// ============================================================================
// Module  : scan_counter
// Brief   : Auto-scan channel pointer with per-channel dwell count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_counter
  import scan_mux_pkg::*;
#(
  parameter int N_CH  = 16,
  parameter int SEL_W = 4,
  parameter int DWELL = 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_advance,
  input  wire logic             i_restart,
  output logic      [SEL_W-1:0] o_scan_ptr
);

  localparam int               c_dw_w       = (DWELL > 1) ? clog2(DWELL) : 1;
  localparam logic [c_dw_w-1:0] c_dwell_last = c_dw_w'(DWELL - 1);
  localparam logic [SEL_W-1:0]  c_ptr_last   = SEL_W'(N_CH - 1);

  logic [c_dw_w-1:0] r_dwell_cnt;
  logic [SEL_W-1:0]  r_scan_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell_cnt <= '0;
      r_scan_ptr  <= '0;
    end else if (i_restart) begin
      r_dwell_cnt <= '0;
      r_scan_ptr  <= '0;
    end else if (i_advance) begin
      if (r_dwell_cnt == c_dwell_last) begin
        r_dwell_cnt <= '0;
        r_scan_ptr  <= (r_scan_ptr == c_ptr_last) ? '0 : r_scan_ptr + SEL_W'(1);
      end else begin
        r_dwell_cnt <= r_dwell_cnt + c_dw_w'(1);
      end
    end
  end

  assign o_scan_ptr = r_scan_ptr;

endmodule

`default_nettype wire

// File: rtl/scan_mux.sv
// ============================================================================
// Module  : scan_mux
// Brief   : N-channel registered mux with valid/ready output and auto-scan.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int N_CH  = 16,
  parameter int WIDTH = 1,
  parameter int SEL_W = 4,
  parameter int DWELL = 1
) (
  input wire logic clk,
  input wire logic rst_n,
  scan_mux_if.slave bus
);

  localparam int               c_depth = 2 ** SEL_W;
  localparam logic [SEL_W:0]   c_n_ch  = (SEL_W + 1)'(N_CH);

  if ((SEL_W != clog2(N_CH)) || (N_CH < 2) || (DWELL < 1)) begin : g_param_bad
    $error("scan_mux: illegal parameter combination");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   w_idx;
  logic [SEL_W-1:0]   w_scan_ptr;
  logic               w_scan_adv;
  logic               w_restart;
  logic               w_slot_free;
  logic               w_capture;
  logic               w_oor;
  logic [WIDTH-1:0]   w_data;
  logic [WIDTH-1:0]   w_ch [c_depth];

  logic [WIDTH-1:0]   r_out;
  logic [SEL_W-1:0]   r_out_ch;
  logic               r_out_valid;
  logic               r_out_err;

  // Channel 0 occupies the most-significant slice; unused indices read zero.
  for (genvar gi = 0; gi < c_depth; gi++) begin : g_chan
    if (gi < N_CH) begin : g_used
      assign w_ch[gi] = bus.in[(N_CH-1-gi)*WIDTH +: WIDTH];
    end else begin : g_unused
      assign w_ch[gi] = '0;
    end
  end

  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_capture   = bus.en && w_slot_free;
  assign w_oor       = {1'b0, w_idx} >= c_n_ch;
  assign w_data      = w_ch[w_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The scan pointer is only observable in SCAN, so it is held at zero in
  // every other state; that makes each entry into SCAN start at channel 0
  // even when the entry happens while the output is stalled.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_idx       = bus.sel;
    w_scan_adv  = 1'b0;
    w_restart   = 1'b1;
    if (bus.en) begin
      w_state_nxt = (bus.mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
    end
    case (w_state_nxt)
      ST_SCAN: begin
        w_restart  = 1'b0;
        w_idx      = (r_state == ST_SCAN) ? w_scan_ptr : '0;
        w_scan_adv = w_slot_free;
      end
      default: begin
      end
    endcase
  end

  scan_counter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W),
    .DWELL (DWELL)
  ) u_scan_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_advance  (w_scan_adv),
    .i_restart  (w_restart),
    .o_scan_ptr (w_scan_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (w_capture) begin
      r_out       <= w_data;
      r_out_ch    <= w_idx;
      r_out_valid <= 1'b1;
      r_out_err   <= w_oor;
    end else if (w_slot_free) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out       = r_out;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;
  assign bus.out_err   = r_out_err;

endmodule

`default_nettype wire

// File: tb/tb_scan_mux.sv
// ============================================================================
// Module  : tb_scan_mux
// Brief   : Directed bench for scan_mux across three configurations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_mux;

  typedef struct packed {
    bit valid;
    int out;
    int ch;
    bit err;
    int scan_n;
  } mdl_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  mdl_t ma, mb, mc;

  scan_mux_if #(.N_CH(16), .WIDTH(1), .SEL_W(4)) ia ();
  scan_mux_if #(.N_CH(4),  .WIDTH(8), .SEL_W(2)) ib ();
  scan_mux_if #(.N_CH(12), .WIDTH(8), .SEL_W(4)) ic ();

  scan_mux #(.N_CH(16), .WIDTH(1), .SEL_W(4), .DWELL(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  scan_mux #(.N_CH(4),  .WIDTH(8), .SEL_W(2), .DWELL(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  scan_mux #(.N_CH(12), .WIDTH(8), .SEL_W(4), .DWELL(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scan position is the number of scan captures since the last non-scan
  // edge; the channel is that count divided by the dwell, modulo N_CH.
  function automatic mdl_t step(mdl_t m, int n_ch, int w, int dwell, logic [191:0] bus,
                                bit en, bit mode, int sel, bit ready);
    mdl_t r;
    bit   slot;
    int   idx;
    r    = m;
    slot = !m.valid || ready;
    if (!(en && mode)) r.scan_n = 0;
    if (en && slot) begin
      idx = mode ? (r.scan_n / dwell) % n_ch : sel;
      if (mode) r.scan_n = r.scan_n + 1;
      r.valid = 1'b1;
      r.ch    = idx;
      r.err   = (idx >= n_ch);
      r.out   = r.err ? 0 : int'((bus >> ((n_ch - 1 - idx) * w)) & ((192'(1) << w) - 192'(1)));
    end else if (slot) begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
      mc <= '0;
    end else begin
      ma <= step(ma, 16, 1, 1, 192'(ia.in), ia.en, ia.mode, int'(ia.sel), ia.out_ready);
      mb <= step(mb, 4,  8, 2, 192'(ib.in), ib.en, ib.mode, int'(ib.sel), ib.out_ready);
      mc <= step(mc, 12, 8, 1, 192'(ic.in), ic.en, ic.mode, int'(ic.sel), ic.out_ready);
    end
  end

  task automatic cmp(string nm, mdl_t m, int v, int o, int c, int e);
    n_tests++;
    if (v != int'(m.valid) || o != m.out || c != m.ch || e != int'(m.err)) begin
      n_fail++;
      $display("FAIL model_%s t=%0t: got v=%0d out=%0h ch=%0d err=%0d, want v=%0d out=%0h ch=%0d err=%0d",
               nm, $time, v, o, c, e, m.valid, m.out, m.ch, m.err);
    end
  endtask

  always @(negedge clk) begin
    cmp("A", ma, int'(ia.out_valid), int'(ia.out), int'(ia.out_ch), int'(ia.out_err));
    cmp("B", mb, int'(ib.out_valid), int'(ib.out), int'(ib.out_ch), int'(ib.out_err));
    cmp("C", mc, int'(ic.out_valid), int'(ic.out), int'(ic.out_ch), int'(ic.out_err));
  end

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [15:0]  onehot;
    logic [95:0]  cvec;
    logic [7:0]   exp_o [9];
    int           exp_c [9];
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    ia.in = '0; ia.sel = '0; ia.mode = 1'b0; ia.en = 1'b0; ia.out_ready = 1'b1;
    ib.in = '0; ib.sel = '0; ib.mode = 1'b0; ib.en = 1'b0; ib.out_ready = 1'b1;
    ic.in = '0; ic.sel = '0; ic.mode = 1'b0; ic.en = 1'b0; ic.out_ready = 1'b1;
    cyc(2);
    chk("rst_a_valid", int'(ia.out_valid), 0);
    chk("rst_a_out",   int'(ia.out), 0);
    chk("rst_b_ch",    int'(ib.out_ch), 0);
    chk("rst_c_err",   int'(ic.out_err), 0);
    rst_n = 1'b1;
    cyc(2);

    // Manual one-hot walk on the 16x1 instance
    ia.en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      onehot = 16'h8000;
      ia.in  = onehot >> s;
      ia.sel = 4'(s);
      cyc(1);
      chk("walk_out",   int'(ia.out), 1);
      chk("walk_ch",    int'(ia.out_ch), s);
      cyc(1);
      chk("walk_valid", int'(ia.out_valid), 1);
      cyc(1);
    end

    // Scan wrap, DWELL=2
    ib.in = 32'hA0B1C2D3;
    ib.mode = 1'b1;
    ib.en = 1'b1;
    exp_o = '{8'hA0, 8'hA0, 8'hB1, 8'hB1, 8'hC2, 8'hC2, 8'hD3, 8'hD3, 8'hA0};
    exp_c = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    for (int k = 0; k < 9; k++) begin
      cyc(1);
      chk("scan_out", int'(ib.out), int'(exp_o[k]));
      chk("scan_ch",  int'(ib.out_ch), exp_c[k]);
    end
    ib.en = 1'b0;

    // Scan under backpressure, then out-of-range select on 12 channels
    cvec = {8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5, 8'h06, 8'h17, 8'h28, 8'h39, 8'h4A, 8'h5B};
    ic.in = cvec;
    ic.mode = 1'b1;
    ic.en = 1'b1;
    cyc(1);
    chk("bp_first", int'(ic.out), 'hA0);
    ic.out_ready = 1'b0;
    ic.in = '1;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("bp_hold_out", int'(ic.out), 'hA0);
      chk("bp_hold_ch",  int'(ic.out_ch), 0);
    end
    ic.in = cvec;
    ic.out_ready = 1'b1;
    cyc(1);
    chk("bp_next_out", int'(ic.out), 'hB1);
    chk("bp_next_ch",  int'(ic.out_ch), 1);
    ic.mode = 1'b0;
    ic.sel = 4'd13;
    cyc(1);
    chk("oor_out", int'(ic.out), 0);
    chk("oor_ch",  int'(ic.out_ch), 13);
    chk("oor_err", int'(ic.out_err), 1);
    ic.sel = 4'd2;
    cyc(1);
    chk("inr_out", int'(ic.out), 'hC2);
    chk("inr_err", int'(ic.out_err), 0);
    ic.sel = 4'd11;
    cyc(1);
    chk("last_ch_out", int'(ic.out), 'h5B);
    ic.en = 1'b0;
    cyc(1);

    // Async reset in the middle of a scan
    ia.in = 16'hFFFF;
    ia.mode = 1'b1;
    cyc(5);
    chk("scan_a_ch", int'(ia.out_ch), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", int'(ia.out_valid), 0);
    chk("async_out",   int'(ia.out), 0);
    chk("async_ch",    int'(ia.out_ch), 0);
    ia.in = 16'h8000;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("post_rst_ch",  int'(ia.out_ch), 0);
    chk("post_rst_out", int'(ia.out), 1);

    // en drop with and without backpressure
    ia.en = 1'b0;
    cyc(1);
    chk("endrop_valid", int'(ia.out_valid), 0);
    chk("endrop_out",   int'(ia.out), 1);
    ia.en = 1'b1;
    ia.mode = 1'b0;
    ia.sel = 4'd3;
    ia.in = 16'h1000;
    cyc(1);
    chk("man3_ch", int'(ia.out_ch), 3);
    ia.en = 1'b0;
    ia.out_ready = 1'b0;
    cyc(2);
    chk("stall_valid", int'(ia.out_valid), 1);
    ia.out_ready = 1'b1;
    cyc(1);
    chk("release_valid", int'(ia.out_valid), 0);
    chk("release_ch",    int'(ia.out_ch), 3);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scan_mux.md
Name: scan_mux

Overview:
Parametrised N-channel, W-bit registered multiplexer, successor to the 16-to-1 combinational mux. It adds a registered output with a valid/ready handshake. It also adds an auto-scan mode that steps through all channels with a programmable dwell. It sits between the sampled-input bank and downstream consumers such as a logger or serialiser, which may apply backpressure.

Parameters:
N_CH, 16, number of input channels (>=2)
WIDTH, 1, bits per channel
SEL_W, 4, select/index width; must equal clog2(N_CH)
DWELL, 1, accepted captures per channel before scan pointer advances (>=1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in  in  N_CH*WIDTH  packed channels; channel 0 is the most-significant slice, channel N_CH-1 the least
sel  in  SEL_W  channel select, used in manual mode
mode  in  1  0 = manual (sel), 1 = auto-scan
en  in  1  capture enable
out  out  WIDTH  registered selected data
out_ch  out  SEL_W  index of channel held in out
out_valid  out  1  out/out_ch hold a capture not yet accepted
out_ready  in  1  consumer accepts when out_valid && out_ready
out_err  out  1  captured index was >= N_CH (non-power-of-2 N_CH only)

Behaviour:
- Reset (async, rst_n=0): out=0, out_ch=0, out_valid=0, out_err=0, scan_ptr=0, dwell_cnt=0, state=IDLE. Clears immediately, mid-transfer included; no capture on the release edge unless en=1 at that edge.
- Slot free: slot_free = !out_valid || out_ready.
- States:
  - IDLE when en=0.
  - MANUAL when en=1 and mode=0.
  - SCAN when en=1 and mode=1.
  - State is evaluated every edge.
- Capture occurs on an edge with en=1 and slot_free:
  - out <= channel[idx], out_ch <= idx, out_valid <= 1.
  - Latency 1 cycle: in/sel sampled at edge k appear on out after edge k.
- idx by mode:
  - MANUAL: idx = sel.
  - SCAN: idx = scan_ptr.
- Scan advance:
  - Each capture in SCAN increments dwell_cnt.
  - When dwell_cnt == DWELL-1, dwell_cnt <= 0 and scan_ptr <= scan_ptr+1.
  - scan_ptr wraps N_CH-1 -> 0.
- Entering SCAN from IDLE or MANUAL: scan_ptr and dwell_cnt restart at 0. The first scan capture is channel 0.
- Backpressure (out_valid && !out_ready): out, out_ch, out_err, scan_ptr and dwell_cnt all frozen. Input changes are ignored.
- en=0 with slot_free: out_valid <= 0. out and out_ch keep their last values.
- Simultaneous accept and capture (out_valid, out_ready, en all 1): new data loads, out_valid stays 1. Full throughput is one per cycle.
- Out-of-range select (idx >= N_CH, manual only): out <= 0, out_ch <= idx, out_err <= 1, out_valid <= 1. out_err clears on the next in-range capture.
- mode change under backpressure takes effect at the first capture after release.

Decomposition:
- Shared package/header holds:
  - MODE_MANUAL=0 and MODE_SCAN=1.
  - State encoding IDLE/MANUAL/SCAN.
  - A clog2 constant function for SEL_W checks.
- One natural sub-module: scan_counter (scan_ptr + dwell_cnt, with inputs advance and restart, and the wrap at N_CH-1). The mux slice select and the output register stay in scan_mux.

Test Plan:
1. Manual walk, N_CH=16, WIDTH=1, out_ready=1: in=16'h8000, sel=0, then one-hot shifted right with sel=1..7 every 3 cycles -> out=1 one cycle after each sel change, out_ch=sel, out_valid=1 throughout.
2. Scan wrap, N_CH=4, WIDTH=8, DWELL=2, in={8'hA0,8'hB1,8'hC2,8'hD3}, mode=1, en=1, ready=1 -> out sequence A0,A0,B1,B1,C2,C2,D3,D3,A0, with out_ch 0,0,1,1,2,2,3,3,0.
3. Backpressure in scan, DWELL=1: ready=0 for 3 cycles after first capture -> out=A0, out_ch=0 held. On ready=1, next value is B1 (no channel skipped).
4. Out-of-range, N_CH=12, SEL_W=4, sel=13 -> out=0, out_ch=13, out_err=1. Then sel=2 -> out_err=0, out=channel 2.
5. Async reset mid-scan: assert rst_n=0 between edges while out_valid=1 -> out, out_valid, out_ch = 0 immediately. After release with mode=1, the first capture is channel 0.
6. en drop: en=0 with ready=1 -> out_valid=0 next edge, out unchanged. en=0 with ready=0 -> out_valid stays 1 until accepted.
